// File: rtl/main_controller_pkg.sv
// Shared constants for the multi-cycle MIPS main controller: opcodes, alu_op classes,
// FSM state encodings, mux selects and the control-word layout. Optional JAL support: MAIN_CTRL_JAL_EN.
package main_controller_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] ALU_MTYPE = 2'b00;
  localparam logic [1:0] ALU_BTYPE = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_JTYPE = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

`ifdef MAIN_CTRL_JAL_EN
  localparam logic JAL_EN = 1'b1;
`else
  localparam logic JAL_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_word_t;

  localparam int CTRL_W = $bits(ctrl_word_t);
  localparam ctrl_word_t CTRL_IDLE = '0;

  function automatic logic opcode_known(input logic [5:0] op);
    logic known;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: known = 1'b1;
      OP_JAL:                                    known = JAL_EN;
      default:                                   known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/main_controller_decode.sv
// Combinational state -> control-word lookup for the main controller.
// The JAL row exists only when MAIN_CTRL_JAL_EN is defined.
module main_controller_decode
  import main_controller_pkg::*;
(
  input  logic [3:0]        state,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_word_t cw_s;

  // Moore output table; unlisted controls stay idle, unknown encodings drive nothing
  always_comb begin
    cw_s = CTRL_IDLE;
    case (state_t'(state))
      S_FETCH: begin
        cw_s.mem_read  = 1'b1;
        cw_s.ir_write  = 1'b1;
        cw_s.pc_write  = 1'b1;
        cw_s.alu_src_b = SRC_B_FOUR;
      end
      S_DECODE: cw_s.alu_src_b = SRC_B_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        cw_s.alu_src_a = 1'b1;
        cw_s.alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        cw_s.mem_read = 1'b1;
        cw_s.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        cw_s.reg_write  = 1'b1;
        cw_s.reg_dst    = REG_DST_RT;
        cw_s.mem_to_reg = MEM_TO_REG_MDR;
        cw_s.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        cw_s.mem_write  = 1'b1;
        cw_s.i_or_d     = 1'b1;
        cw_s.instr_done = 1'b1;
      end
      S_R_EXEC: begin
        cw_s.alu_src_a = 1'b1;
        cw_s.alu_src_b = SRC_B_REG;
        cw_s.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        cw_s.reg_write  = 1'b1;
        cw_s.reg_dst    = REG_DST_RD;
        cw_s.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw_s.alu_src_a     = 1'b1;
        cw_s.alu_op        = ALU_BTYPE;
        cw_s.pc_write_cond = 1'b1;
        cw_s.pc_src        = PC_SRC_ALUOUT;
        cw_s.instr_done    = 1'b1;
      end
      S_JUMP: begin
        cw_s.pc_write   = 1'b1;
        cw_s.pc_src     = PC_SRC_JUMP;
        cw_s.alu_op     = ALU_JTYPE;
        cw_s.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        cw_s.reg_write  = 1'b1;
        cw_s.reg_dst    = REG_DST_RT;
        cw_s.mem_to_reg = MEM_TO_REG_ALUOUT;
        cw_s.instr_done = 1'b1;
      end
`ifdef MAIN_CTRL_JAL_EN
      // r31 takes the PC that FETCH already advanced to PC+4
      S_JAL: begin
        cw_s.pc_write   = 1'b1;
        cw_s.pc_src     = PC_SRC_JUMP;
        cw_s.reg_write  = 1'b1;
        cw_s.reg_dst    = REG_DST_R31;
        cw_s.mem_to_reg = MEM_TO_REG_PC;
        cw_s.alu_op     = ALU_JTYPE;
        cw_s.instr_done = 1'b1;
      end
`endif
      default: cw_s = CTRL_IDLE;
    endcase
  end

  assign ctrl = cw_s;

endmodule

// File: rtl/main_controller.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and reset gating.
// Define MAIN_CTRL_JAL_EN to support JAL (opcode 000011); otherwise it is treated as illegal.
module main_controller
  import main_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t            state_r;
  state_t            state_next_s;
  logic              mem_store_r;
  logic [3:0]        dec_state_s;
  logic [CTRL_W-1:0] ctrl_s;
  ctrl_word_t        cw_s;
  logic              illegal_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Remembers whether the decoded memory op is a store, so MEM_ADDR needs no second opcode look
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_store_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      mem_store_r <= (opcode == OP_SW);
    end else begin
      mem_store_r <= mem_store_r;
    end
  end

  // Next-state logic; anything unexpected falls back to FETCH
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: state_next_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_next_s = S_R_EXEC;
          OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_J:         state_next_s = S_JUMP;
          OP_ADDI:      state_next_s = S_ADDI_EXEC;
`ifdef MAIN_CTRL_JAL_EN
          OP_JAL:       state_next_s = S_JAL;
`endif
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (mem_store_r) begin
          state_next_s = S_MEM_WRITE;
        end else begin
          state_next_s = S_MEM_READ;
        end
      end
      S_MEM_READ:  state_next_s = S_MEM_WB;
      S_R_EXEC:    state_next_s = S_R_WB;
      S_ADDI_EXEC: state_next_s = S_ADDI_WB;
      default:     state_next_s = S_FETCH;
    endcase
  end

  // While rst is high the outputs show FETCH with every write enable suppressed
  always_comb begin
    if (rst) begin
      dec_state_s = S_FETCH;
      illegal_s   = 1'b0;
    end else begin
      dec_state_s = state_r;
      illegal_s   = (state_r == S_DECODE) && !opcode_known(opcode);
    end
  end

  main_controller_decode u_decode (
    .state (dec_state_s),
    .ctrl  (ctrl_s)
  );

  assign cw_s = ctrl_word_t'(ctrl_s);

  // Output drive with write-enable gating
  always_comb begin
    pc_write      = cw_s.pc_write      & ~rst;
    pc_write_cond = cw_s.pc_write_cond & ~rst;
    mem_read      = cw_s.mem_read      & ~rst;
    mem_write     = cw_s.mem_write     & ~rst;
    ir_write      = cw_s.ir_write      & ~rst;
    reg_write     = cw_s.reg_write     & ~rst;
    i_or_d        = cw_s.i_or_d;
    alu_src_a     = cw_s.alu_src_a;
    alu_src_b     = cw_s.alu_src_b;
    pc_src        = cw_s.pc_src;
    reg_dst       = cw_s.reg_dst;
    mem_to_reg    = cw_s.mem_to_reg;
    alu_op        = cw_s.alu_op;
    instr_done    = (cw_s.instr_done | illegal_s) & ~rst;
    illegal_op    = illegal_s;
  end

endmodule
